// File: rtl/jtcps1_sdram_pkg.sv
// Shared types for the CPS1 SDRAM scheduler: FSM states, bank indices, command record.
package jtcps1_sdram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RFSH  = 2'd2
    } state_e;

    localparam logic [1:0] BA_MAIN = 2'd0;
    localparam logic [1:0] BA_PCM  = 2'd1;
    localparam logic [1:0] BA_OBJ2 = 2'd2;
    localparam logic [1:0] BA_GFX  = 2'd3;

    // Address travels separately because its width is a parameter of the top.
    typedef struct packed {
        logic [1:0]  ba;
        logic        wr;
        logic        rfsh;
        logic        prog;
        logic [15:0] din;
        logic [1:0]  mask;
    } cmd_t;

endpackage

// File: rtl/jtcps1_sdram_rr.sv
// Combinational 4-way picker: requests in prio_i win first (lowest index),
// otherwise round-robin over the rest starting at ptr_i.
module jtcps1_sdram_rr (
    input  logic [3:0] req_i,
    input  logic [3:0] prio_i,
    input  logic [1:0] ptr_i,
    output logic       gnt_vld_o,
    output logic [1:0] gnt_idx_o,
    output logic       gnt_prio_o
);
    logic [3:0] hi_req;
    logic [3:0] lo_req;
    logic [1:0] cand;

    assign hi_req = req_i & prio_i;
    assign lo_req = req_i & ~prio_i;

    always_comb begin
        gnt_vld_o  = |req_i;
        gnt_prio_o = |hi_req;
        gnt_idx_o  = 2'd0;
        cand       = 2'd0;
        if (|hi_req) begin
            for (int i = 3; i >= 0; i--) begin
                if (hi_req[i]) gnt_idx_o = 2'(i);
            end
        end else begin
            // Scanned backwards so the candidate closest to ptr_i is the last write.
            for (int k = 3; k >= 0; k--) begin
                cand = ptr_i + 2'(k);
                if (lo_req[cand]) gnt_idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/jtcps1_sdram_sched.sv
// Four-bank SDRAM command scheduler with refresh insertion and tagged read return.
// Grant reaches cmd_valid one cycle after request; cmd_* held until cmd_ready, ack one cycle after handshake.
module jtcps1_sdram_sched
    import jtcps1_sdram_pkg::*;
#(
    parameter int AW       = 23,
    parameter int BA0_PRIO = 1,
    parameter int RFSH_GAP = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    ba_rd,
    input  logic          ba0_wr,
    input  logic [AW-1:0] ba0_addr,
    input  logic [AW-1:0] ba1_addr,
    input  logic [AW-1:0] ba2_addr,
    input  logic [AW-1:0] ba3_addr,
    input  logic [15:0]   ba0_din,
    input  logic [1:0]    ba0_din_m,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic [1:0]    prog_mask,
    input  logic [1:0]    prog_ba,
    output logic          prog_rdy,
    input  logic          refresh_en,
    output logic [3:0]    ba_ack,
    output logic [3:0]    ba_rdy,
    output logic [31:0]   data_read,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_ba,
    output logic [AW-1:0] cmd_addr,
    output logic          cmd_wr,
    output logic          cmd_rfsh,
    output logic [15:0]   cmd_din,
    output logic [1:0]    cmd_mask,
    input  logic          rsp_valid,
    input  logic [1:0]    rsp_ba,
    input  logic [31:0]   rsp_data
);
    localparam logic [3:0] PRIO_MASK = (BA0_PRIO != 0) ? 4'b0001 : 4'b0000;

    state_e        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    pend_q, pend_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [7:0]    gap_q, gap_d;
    logic          err_q, err_d;
    logic [3:0]    ack_q, ack_d;
    logic [3:0]    rdy_q, rdy_d;
    logic          prog_rdy_q, prog_rdy_d;
    logic [31:0]   data_q, data_d;

    logic [3:0]    pend_eff;
    logic          rsp_hit;
    logic [3:0]    elig;
    logic          gnt_vld;
    logic [1:0]    gnt_idx;
    logic          gnt_prio;
    logic [AW-1:0] gnt_addr;

    // A response retires its bank before this cycle's arbitration looks at it.
    always_comb begin
        rsp_hit  = rsp_valid & pend_q[rsp_ba];
        pend_eff = pend_q;
        if (rsp_hit) pend_eff[rsp_ba] = 1'b0;
        elig = {ba_rd[3:1], ba_rd[0] | ba0_wr} & ~pend_eff;
    end

    jtcps1_sdram_rr u_rr (
        .req_i      (elig),
        .prio_i     (PRIO_MASK),
        .ptr_i      (ptr_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_idx_o  (gnt_idx),
        .gnt_prio_o (gnt_prio)
    );

    always_comb begin
        case (gnt_idx)
            BA_MAIN: gnt_addr = ba0_addr;
            BA_PCM:  gnt_addr = ba1_addr;
            BA_OBJ2: gnt_addr = ba2_addr;
            default: gnt_addr = ba3_addr;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        pend_d     = pend_eff;
        ptr_d      = ptr_q;
        gap_d      = (gap_q != 8'd0) ? gap_q - 8'd1 : 8'd0;
        err_d      = err_q | (rsp_valid & ~rsp_hit);
        ack_d      = 4'b0000;
        rdy_d      = 4'b0000;
        prog_rdy_d = 1'b0;
        data_d     = data_q;

        if (rsp_hit) begin
            rdy_d  = 4'b0001 << rsp_ba;
            data_d = rsp_data;
        end

        case (state_q)
            IDLE: begin
                if (prog_we) begin
                    cmd_d.ba   = prog_ba;
                    cmd_d.wr   = 1'b1;
                    cmd_d.rfsh = 1'b0;
                    cmd_d.prog = 1'b1;
                    cmd_d.din  = prog_data;
                    cmd_d.mask = prog_mask;
                    addr_d     = prog_addr;
                    state_d    = ISSUE;
                end else if (refresh_en && gap_q == 8'd0 && pend_eff == 4'b0000) begin
                    cmd_d      = '0;
                    cmd_d.rfsh = 1'b1;
                    addr_d     = '0;
                    state_d    = RFSH;
                end else if (gnt_vld) begin
                    cmd_d      = '0;
                    cmd_d.ba   = gnt_idx;
                    cmd_d.wr   = (gnt_idx == BA_MAIN) & ba0_wr;
                    if (cmd_d.wr) begin
                        cmd_d.din  = ba0_din;
                        cmd_d.mask = ba0_din_m;
                    end
                    addr_d  = gnt_addr;
                    state_d = ISSUE;
                    // Priority wins for bank 0 leave the 1-3 rotation where it was.
                    if (!gnt_prio) ptr_d = gnt_idx + 2'd1;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                    if (cmd_q.prog) begin
                        prog_rdy_d = 1'b1;
                    end else begin
                        ack_d = 4'b0001 << cmd_q.ba;
                        if (!cmd_q.wr) pend_d[cmd_q.ba] = 1'b1;
                    end
                    cmd_d  = '0;
                    addr_d = '0;
                end
            end
            RFSH: begin
                if (cmd_ready) begin
                    state_d = IDLE;
                    gap_d   = 8'(RFSH_GAP - 1);
                    cmd_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            pend_q     <= 4'b0000;
            ptr_q      <= 2'd1;
            gap_q      <= 8'd0;
            err_q      <= 1'b0;
            ack_q      <= 4'b0000;
            rdy_q      <= 4'b0000;
            prog_rdy_q <= 1'b0;
            data_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            rdy_q      <= rdy_d;
            prog_rdy_q <= prog_rdy_d;
            data_q     <= data_d;
        end
    end

    assign cmd_valid = (state_q != IDLE);
    assign cmd_ba    = cmd_q.ba;
    assign cmd_addr  = addr_q;
    assign cmd_wr    = cmd_q.wr;
    assign cmd_rfsh  = cmd_q.rfsh;
    assign cmd_din   = cmd_q.din;
    assign cmd_mask  = cmd_q.mask;
    assign ba_ack    = ack_q;
    assign ba_rdy    = rdy_q;
    assign prog_rdy  = prog_rdy_q;
    assign data_read = data_q;

endmodule

// File: tb/tb_jtcps1_sdram_sched.sv
// Bench for jtcps1_sdram_sched: per-cycle reference model plus directed scenarios.
module tb_jtcps1_sdram_sched;
    localparam int AW  = 23;
    localparam int GAP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    ba_rd = '0;
    logic          ba0_wr = 1'b0;
    logic [AW-1:0] ba0_addr = '0, ba1_addr = '0, ba2_addr = '0, ba3_addr = '0;
    logic [15:0]   ba0_din = '0;
    logic [1:0]    ba0_din_m = '0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic [1:0]    prog_mask = '0, prog_ba = '0;
    logic          refresh_en = 1'b0, cmd_ready = 1'b0, rsp_valid = 1'b0;
    logic [1:0]    rsp_ba = '0;
    logic [31:0]   rsp_data = '0;
    wire logic          prog_rdy, cmd_valid, cmd_wr, cmd_rfsh;
    wire logic [3:0]    ba_ack, ba_rdy;
    wire logic [31:0]   data_read;
    wire logic [1:0]    cmd_ba, cmd_mask;
    wire logic [AW-1:0] cmd_addr;
    wire logic [15:0]   cmd_din;

    jtcps1_sdram_sched #(.AW(AW), .BA0_PRIO(1), .RFSH_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .ba_rd(ba_rd), .ba0_wr(ba0_wr),
        .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba0_din(ba0_din), .ba0_din_m(ba0_din_m), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba), .prog_rdy(prog_rdy),
        .refresh_en(refresh_en), .ba_ack(ba_ack), .ba_rdy(ba_rdy), .data_read(data_read),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr),
        .cmd_wr(cmd_wr), .cmd_rfsh(cmd_rfsh), .cmd_din(cmd_din), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ba(rsp_ba), .rsp_data(rsp_data)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model (bank 0 priority, banks 1-3 rotate).
    bit            m_busy, m_rfsh, m_prog, m_wr;
    logic [1:0]    m_ba, m_mask;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_din;
    bit   [3:0]    m_pend;
    int            m_ptr, m_gap;
    logic [3:0]    e_ack, e_rdy;
    logic          e_prog_rdy;
    logic [31:0]   e_data;

    int rq_ba[$];
    int rq_due[$];
    int dly_lo = 1, dly_hi = 1;
    bit hold = 0, rsp_en = 0, rand_mode = 0;

    int hs_ba[$];
    int hs_rf[$];
    int hs_cyc[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_rfsh = 0; m_prog = 0; m_wr = 0; m_ba = '0; m_mask = '0;
        m_addr = '0; m_din = '0; m_pend = '0; m_ptr = 1; m_gap = 0;
        e_ack = '0; e_rdy = '0; e_prog_rdy = 1'b0; e_data = '0;
        rq_ba.delete(); rq_due.delete();
    endtask

    function automatic logic [AW-1:0] bank_addr(input int b);
        case (b)
            0: return ba0_addr;
            1: return ba1_addr;
            2: return ba2_addr;
            default: return ba3_addr;
        endcase
    endfunction

    // Advances the model over the cycle whose inputs are still on the pins.
    task automatic model_step();
        bit [3:0] want;
        int gap_n, win, b;
        e_ack = '0; e_rdy = '0; e_prog_rdy = 1'b0;
        if (rsp_valid && m_pend[rsp_ba]) begin
            m_pend[rsp_ba] = 1'b0;
            e_rdy[rsp_ba]  = 1'b1;
            e_data         = rsp_data;
        end
        gap_n = (m_gap > 0) ? m_gap - 1 : 0;
        if (m_busy) begin
            if (cmd_ready) begin
                m_busy = 0;
                if (m_rfsh) gap_n = GAP - 1;
                else if (m_prog) e_prog_rdy = 1'b1;
                else begin
                    e_ack[m_ba] = 1'b1;
                    if (!m_wr) begin
                        m_pend[m_ba] = 1'b1;
                        rq_ba.push_back(int'(m_ba));
                        rq_due.push_back(cyc + $urandom_range(dly_hi, dly_lo));
                    end
                end
            end
        end else if (prog_we) begin
            m_busy = 1; m_rfsh = 0; m_prog = 1; m_wr = 1; m_ba = prog_ba;
            m_addr = prog_addr; m_din = prog_data; m_mask = prog_mask;
        end else if (refresh_en && m_gap == 0 && m_pend == 0) begin
            m_busy = 1; m_rfsh = 1; m_prog = 0; m_wr = 0;
        end else begin
            want = ba_rd | {3'b000, ba0_wr};
            win = -1;
            if (want[0] && !m_pend[0]) win = 0;
            else begin
                for (int k = 0; k < 4; k++) begin
                    b = (m_ptr + k) % 4;
                    if (win < 0 && b != 0 && want[b] && !m_pend[b]) begin
                        win = b;
                        m_ptr = (b + 1) % 4;
                    end
                end
            end
            if (win >= 0) begin
                m_busy = 1; m_rfsh = 0; m_prog = 0; m_ba = 2'(win);
                m_wr = (win == 0) && ba0_wr;
                m_addr = bank_addr(win);
                m_din = ba0_din; m_mask = ba0_din_m;
            end
        end
        m_gap = gap_n;
    endtask

    task automatic compare();
        chk("cmd_valid", cmd_valid, m_busy);
        if (m_busy) begin
            chk("cmd_rfsh", cmd_rfsh, m_rfsh);
            if (!m_rfsh) begin
                chk("cmd_ba", cmd_ba, m_ba);
                chk("cmd_wr", cmd_wr, m_wr);
                chk("cmd_addr", cmd_addr, m_addr);
                if (m_wr) begin
                    chk("cmd_din", cmd_din, m_din);
                    chk("cmd_mask", cmd_mask, m_mask);
                end
            end
        end
        chk("ba_ack", ba_ack, e_ack);
        chk("ba_rdy", ba_rdy, e_rdy);
        chk("prog_rdy", prog_rdy, e_prog_rdy);
        if (e_rdy != 0) chk("data_read", data_read, e_data);
    endtask

    task automatic tick();
        @(negedge clk);
        if (cmd_valid && cmd_ready) begin
            hs_ba.push_back(int'(cmd_ba));
            hs_rf.push_back(int'(cmd_rfsh));
            hs_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        compare();
    endtask

    task automatic drive();
        int b;
        if (!hold) begin
            ba_rd = ba_rd & ~ba_ack;
            if (ba_ack[0]) ba0_wr = 1'b0;
            if (prog_rdy) prog_we = 1'b0;
        end
        rsp_valid = 1'b0;
        if (rsp_en && rq_ba.size() > 0 && rq_due[0] <= cyc) begin
            rsp_valid = 1'b1;
            rsp_ba    = 2'(rq_ba.pop_front());
            void'(rq_due.pop_front());
            rsp_data  = $urandom;
        end
        if (rand_mode) begin
            cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) refresh_en = ~refresh_en;
            for (int i = 1; i < 4; i++) begin
                if (!ba_rd[i] && $urandom_range(0, 3) == 0) begin
                    ba_rd[i] = 1'b1;
                    case (i)
                        1: ba1_addr = AW'($urandom);
                        2: ba2_addr = AW'($urandom);
                        default: ba3_addr = AW'($urandom);
                    endcase
                end
            end
            if (!ba_rd[0] && !ba0_wr && $urandom_range(0, 3) == 0) begin
                ba0_addr = AW'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    ba0_wr = 1'b1; ba0_din = 16'($urandom); ba0_din_m = 2'($urandom);
                end else ba_rd[0] = 1'b1;
            end
            if (!prog_we && $urandom_range(0, 39) == 0) begin
                prog_we = 1'b1; prog_addr = AW'($urandom); prog_data = 16'($urandom);
                prog_mask = 2'($urandom); prog_ba = 2'($urandom);
            end
            if (!rsp_valid && $urandom_range(0, 49) == 0) begin
                b = $urandom_range(0, 3);
                if (!m_pend[b]) begin
                    rsp_valid = 1'b1; rsp_ba = 2'(b); rsp_data = $urandom;
                end
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ba_rd = '0; ba0_wr = 1'b0; prog_we = 1'b0; refresh_en = 1'b0;
        cmd_ready = 1'b0; rsp_valid = 1'b0;
        hold = 0; rsp_en = 0; rand_mode = 0; dly_lo = 1; dly_hi = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_ack", ba_ack, 4'b0000);
        chk("rst_rdy", ba_rdy, 4'b0000);
        chk("rst_prog_rdy", prog_rdy, 1'b0);
        chk("rst_data", data_read, 32'd0);
        chk("rst_rfsh", cmd_rfsh, 1'b0);
        rst_n = 1'b1;
        hs_ba.delete(); hs_rf.delete(); hs_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr[6];
        int exp_pr[6];
        int run, maxrun, acks, prdys, found;
        int rf_c[$];
        logic [3:0] seen;

        // Round-robin over banks 1-3 with requests held.
        do_reset();
        hold = 1; rsp_en = 1; cmd_ready = 1'b1; ba_rd = 4'b1110;
        step(20);
        exp_rr = '{1, 2, 3, 1, 2, 3};
        chk("rr_len", hs_ba.size() >= 6, 1'b1);
        for (int i = 0; i < 6; i++)
            chk("rr_seq", (i < hs_ba.size()) ? 64'(hs_ba[i]) : 64'd99, 64'(exp_rr[i]));

        // Bank 0 priority with all banks requesting.
        do_reset();
        hold = 1; rsp_en = 1; cmd_ready = 1'b1; ba_rd = 4'b1111;
        step(40);
        exp_pr = '{0, 1, 0, 2, 0, 3};
        for (int i = 0; i < 6; i++)
            chk("prio_seq", (i < hs_ba.size()) ? 64'(hs_ba[i]) : 64'd99, 64'(exp_pr[i]));
        run = 0; maxrun = 0; seen = '0;
        foreach (hs_ba[i]) begin
            seen[hs_ba[i]] = 1'b1;
            if (hs_ba[i] == 0) begin
                run++;
                if (run > maxrun) maxrun = run;
            end else run = 0;
        end
        chk("prio_b0_run_le3", maxrun <= 3, 1'b1);
        chk("prio_all_served", seen, 4'b1111);

        // Tagged read return for bank 2.
        do_reset();
        cmd_ready = 1'b1; ba2_addr = 23'h012345; ba_rd = 4'b0100;
        tick();
        chk("rd2_cmd_valid", cmd_valid, 1'b1);
        chk("rd2_cmd_ba", cmd_ba, 2'd2);
        chk("rd2_cmd_addr", cmd_addr, 23'h012345);
        tick();
        chk("rd2_ack", ba_ack, 4'b0100);
        drive();
        rsp_valid = 1'b1; rsp_ba = 2'd2; rsp_data = 32'hDEADBEEF;
        tick();
        chk("rd2_rdy", ba_rdy, 4'b0100);
        chk("rd2_data", data_read, 32'hDEADBEEF);
        rsp_valid = 1'b0; ba_rd = 4'b0100;
        tick();
        chk("rd2_regrant", cmd_valid, 1'b1);

        // Refresh spacing, then deferral while a read is outstanding.
        do_reset();
        refresh_en = 1'b1; cmd_ready = 1'b1;
        step(40);
        foreach (hs_rf[i]) if (hs_rf[i] == 1) rf_c.push_back(hs_cyc[i]);
        chk("rfsh_count_ge3", rf_c.size() >= 3, 1'b1);
        for (int i = 0; i + 1 < rf_c.size(); i++)
            chk("rfsh_period", 64'(rf_c[i+1] - rf_c[i]), 64'(GAP + 1));
        refresh_en = 1'b0;
        step(2);
        ba_rd = 4'b0001;
        step(4);
        refresh_en = 1'b1;
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            drive();
            if (cmd_valid) acks++;
        end
        chk("rfsh_deferred", acks, 0);
        rsp_valid = 1'b1; rsp_ba = 2'd0; rsp_data = 32'h0BADF00D;
        found = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            drive();
            if (cmd_valid && cmd_rfsh) found = 1;
        end
        chk("rfsh_after_pend_clear", found, 1);

        // Download writes block bank grants.
        do_reset();
        hold = 1; rsp_en = 1; cmd_ready = 1'b1; ba_rd = 4'b1111;
        prog_we = 1'b1; prog_addr = 23'h055AA5; prog_data = 16'hC0DE; prog_mask = 2'b01; prog_ba = 2'd3;
        acks = 0; prdys = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            drive();
            if (ba_ack != 0) acks++;
            if (prog_rdy) prdys++;
        end
        chk("prog_no_bank_ack", acks, 0);
        chk("prog_rdy_count_ge5", prdys >= 5, 1'b1);
        prog_we = 1'b0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            drive();
            if (ba_ack != 0) found = 1;
        end
        chk("prog_then_bank", found, 1);

        // Randomised traffic against the model.
        do_reset();
        rand_mode = 1; rsp_en = 1; dly_lo = 0; dly_hi = 5;
        step(4000);
        rand_mode = 0; ba_rd = '0; ba0_wr = 1'b0; prog_we = 1'b0; cmd_ready = 1'b1;
        step(40);

        // Async reset while a command is held and two reads are outstanding.
        do_reset();
        cmd_ready = 1'b1; ba_rd = 4'b0011;
        step(6);
        ba_rd = 4'b0100; cmd_ready = 1'b0;
        step(3);
        chk("mid_issue_valid", cmd_valid, 1'b1);
        chk("mid_issue_ba", cmd_ba, 2'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", cmd_valid, 1'b0);
        model_reset();
        ba_rd = '0;
        #1 rst_n = 1'b1;
        rsp_valid = 1'b1; rsp_ba = 2'd0; rsp_data = 32'h12345678;
        tick();
        chk("stray_rsp_no_rdy", ba_rdy, 4'b0000);
        rsp_valid = 1'b0; ba_rd = 4'b0001; cmd_ready = 1'b1;
        tick();
        chk("post_rst_grant", cmd_valid, 1'b1);
        chk("post_rst_grant_ba", cmd_ba, 2'd0);
        ba_rd = '0;
        step(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
